bus_master_if: RTL

Bus-master side of the shared bus: turns a single-word client request into the bus request/grant handshake, address-strobe access and ready wait, then returns read data or completion to the client. One instance sits between each bus master (CPU IF/MEM stages, DMA) and the bus arbiter/slave mux. It provides the request and release behaviour the round-robin arbiter depends on, plus a per-access ready timeout.

---
 rtl/bus_master_if.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - bus-master request/grant/strobe handshake with per-access ready timeout
module bus_master_if #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_rw,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rd_data,
    output logic        m_req_n,
    input  logic        m_grnt_n,
    output logic        m_as_n,
    output logic        m_rw,
    output logic [29:0] m_addr,
    output logic [31:0] m_wr_data,
    input  logic [31:0] m_rd_data,
    input  logic        m_rdy_n
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        m_req_n_q, m_req_n_d;
    logic        m_as_n_q, m_as_n_d;
    logic        m_rw_q, m_rw_d;
    logic [29:0] m_addr_q, m_addr_d;
    logic [31:0] m_wr_data_q, m_wr_data_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            m_req_n_q   <= 1'b1;
            m_as_n_q    <= 1'b1;
            m_rw_q      <= 1'b1;
            m_addr_q    <= 30'd0;
            m_wr_data_q <= 32'd0;
            rd_data_q   <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_req_n_q   <= m_req_n_d;
            m_as_n_q    <= m_as_n_d;
            m_rw_q      <= m_rw_d;
            m_addr_q    <= m_addr_d;
            m_wr_data_q <= m_wr_data_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = REQ;
            REQ:     if (!m_grnt_n) state_d = ACCESS;
            ACCESS:  if (!m_rdy_n || cnt_q == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready has priority over the timeout on the final counted cycle.
    always_comb begin
        cnt_d       = cnt_q;
        m_req_n_d   = m_req_n_q;
        m_as_n_d    = m_as_n_q;
        m_rw_d      = m_rw_q;
        m_addr_d    = m_addr_q;
        m_wr_data_d = m_wr_data_q;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    m_req_n_d   = 1'b0;
                    m_rw_d      = req_rw;
                    m_addr_d    = req_addr;
                    m_wr_data_d = req_wr_data;
                end
            end
            REQ: begin
                if (!m_grnt_n) begin
                    m_as_n_d = 1'b0;
                    cnt_d    = 8'd0;
                end
            end
            ACCESS: begin
                if (!m_rdy_n) begin
                    if (m_rw_q) rd_data_d = m_rd_data;
                    done_d    = 1'b1;
                    m_req_n_d = 1'b1;
                    m_as_n_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    rd_data_d = 32'd0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    m_req_n_d = 1'b1;
                    m_as_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                m_req_n_d = 1'b1;
                m_as_n_d  = 1'b1;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rd_data_q;
    assign m_req_n   = m_req_n_q;
    assign m_as_n    = m_as_n_q;
    assign m_rw      = m_rw_q;
    assign m_addr    = m_addr_q;
    assign m_wr_data = m_wr_data_q;

endmodule
